// File: rtl/fwd_converter_1025_1024_1023.sv
// Binary-to-RNS forward converter: X -> (X mod 2^N+1, X mod 2^N, X mod 2^N-1); RANGE_CHECK_EN adds out_of_range.
// Latency: 2 cycles from acceptance to out_valid, sustained throughput 1 item/cycle.
// Backpressure: stalls ripple back through in_ready; outputs hold stable while out_valid && !out_ready.
module fwd_converter_1025_1024_1023 #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     x1,
    output logic [N-1:0]   x2,
    output logic [N-1:0]   x3
`ifdef RANGE_CHECK_EN
    ,
    output logic           out_of_range
`endif
);

    localparam logic signed [N+1:0] MOD_P   = (N+2)'(2**N + 1);
    localparam logic [N-1:0]        ALL_ONE = '1;
`ifdef RANGE_CHECK_EN
    localparam longint unsigned     M_FULL  = ((64'd1 << N) + 64'd1) * (64'd1 << N) * ((64'd1 << N) - 64'd1);
    localparam logic [3*N-1:0]      X_MAX   = (3*N)'(M_FULL - 64'd1);
`endif

    typedef struct packed {
        logic [N-1:0] b0;
        logic [N-1:0] b1;
        logic [N:0]   s;
        logic [N+1:0] t;
`ifdef RANGE_CHECK_EN
        logic         oor;
`endif
    } s1_t;

    logic [N-1:0] blk0, blk1, blk2;
    s1_t          s1_d, s1_q;
    logic         s1_vld_q, s2_vld_q;
    logic         s1_en, s2_en;

    logic [N:0]          u;
    logic [N-1:0]        v;
    logic signed [N+1:0] d;
    logic [N:0]          x1_d, x1_q;
    logic [N-1:0]        x2_d, x2_q;
    logic [N-1:0]        x3_d, x3_q;
`ifdef RANGE_CHECK_EN
    logic                oor_q;
`endif

    assign s2_en     = !s2_vld_q || out_ready;
    assign s1_en     = !s1_vld_q || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_vld_q;
    assign x1        = x1_q;
    assign x2        = x2_q;
    assign x3        = x3_q;
`ifdef RANGE_CHECK_EN
    assign out_of_range = oor_q;
`endif

    assign blk0 = in_data[N-1:0];
    assign blk1 = in_data[2*N-1:N];
    assign blk2 = in_data[3*N-1:2*N];

    // Stage 1: block sums; 2^N folds to -1 for the +1 modulus and +1 for the -1 modulus.
    always_comb begin
        s1_d    = '0;
        s1_d.b0 = blk0;
        s1_d.b1 = blk1;
        s1_d.s  = {1'b0, blk0} + {1'b0, blk2};
        s1_d.t  = {2'b00, blk0} + {2'b00, blk1} + {2'b00, blk2};
`ifdef RANGE_CHECK_EN
        s1_d.oor = (in_data > X_MAX);
`endif
    end

    // Stage 2: end-around-carry fold for mod 2^N-1, single correction step for mod 2^N+1.
    always_comb begin
        u    = {1'b0, s1_q.t[N-1:0]} + (N+1)'(s1_q.t[N+1:N]);
        v    = u[N-1:0] + N'(u[N]);
        x3_d = (v == ALL_ONE) ? '0 : v;
        x2_d = s1_q.b0;
        d    = signed'({1'b0, s1_q.s}) - signed'({2'b00, s1_q.b1});
        if (d[N+1]) begin
            x1_d = (N+1)'(d + MOD_P);
        end else if (d >= MOD_P) begin
            x1_d = (N+1)'(d - MOD_P);
        end else begin
            x1_d = (N+1)'(d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            x3_q     <= '0;
`ifdef RANGE_CHECK_EN
            oor_q    <= 1'b0;
`endif
        end else begin
            if (s1_en) begin
                s1_vld_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_en) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    x1_q  <= x1_d;
                    x2_q  <= x2_d;
                    x3_q  <= x3_d;
`ifdef RANGE_CHECK_EN
                    oor_q <= s1_q.oor;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_converter_1025_1024_1023.sv
// Randomized and directed bench for fwd_converter_1025_1024_1023: residues checked against X mod m
// and reconstructed by CRT; handshake ordering, backpressure hold and async reset checked alongside.
module tb_fwd_converter_1025_1024_1023;

    localparam longint M_FULL = 64'd1025 * 64'd1024 * 64'd1023;
    localparam longint X_MAX  = M_FULL - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] x1;
    logic [9:0]  x2;
    logic [9:0]  x3;
`ifdef RANGE_CHECK_EN
    logic        out_of_range;
`endif

    fwd_converter_1025_1024_1023 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3)
`ifdef RANGE_CHECK_EN
        ,
        .out_of_range (out_of_range)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_in   = 0;
    int n_out  = 0;
    longint exp_q[$];
    longint last_out_x;
    bit          hold_pend;
    logic [30:0] hold_val;
    longint inv1, inv2, inv3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint mod_inv(input longint a, input longint m);
        for (longint k = 1; k < m; k++) begin
            if ((a * k) % m == 1) return k;
        end
        return 0;
    endfunction

    function automatic longint crt(input longint r1, input longint r2, input longint r3);
        longint acc;
        acc = r1 * inv1 % 1025 * (1024 * 1023)
            + r2 * inv2 % 1024 * (1025 * 1023)
            + r3 * inv3 % 1023 * (1025 * 1024);
        return acc % M_FULL;
    endfunction

    // Scoreboard: inputs stable between posedge+1 and next posedge, so sample mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {x1, x2, x3}, hold_val);
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {x1, x2, x3};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    longint x;
                    x = exp_q.pop_front();
                    chk("x1", x1, x % 1025);
                    chk("x2", x2, x % 1024);
                    chk("x3", x3, x % 1023);
`ifdef RANGE_CHECK_EN
                    chk("out_of_range", out_of_range, (x > X_MAX) ? 1 : 0);
`endif
                    if (x <= X_MAX) chk("crt_rebuild", crt(x1, x2, x3), x);
                    last_out_x = x;
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(longint'(in_data));
                n_in++;
            end
        end
    end

    task automatic send(input logic [29:0] x);
        int guard = 0;
        bit acc;
        in_valid = 1'b1;
        in_data  = x;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [29:0] pick_x();
        logic [9:0] edge_v [4];
        logic [29:0] x;
        edge_v[0] = 10'd0; edge_v[1] = 10'd1; edge_v[2] = 10'd1022; edge_v[3] = 10'd1023;
        if ($urandom_range(0, 3) == 0) begin
            x = {edge_v[$urandom_range(0, 3)], edge_v[$urandom_range(0, 3)], edge_v[$urandom_range(0, 3)]};
            if (longint'(x) > X_MAX) x = 30'(X_MAX);
        end else begin
            x = 30'($urandom_range(0, 32'(X_MAX)));
        end
        return x;
    endfunction

    bit rand_done;
    int base;
    logic [29:0] dir_vec [9];

    initial begin
        inv1 = mod_inv(longint'(1024 * 1023) % 1025, 1025);
        inv2 = mod_inv(longint'(1025 * 1023) % 1024, 1024);
        inv3 = mod_inv(longint'(1025 * 1024) % 1023, 1023);
        hold_pend = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_x", {x1, x2, x3}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Two-cycle latency with X = 0
        idle(1);
        in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_x", {x1, x2, x3}, 0);
        idle(2);

        // Directed boundaries, back-to-back
        dir_vec[0] = 30'd1073740799; dir_vec[1] = 30'd1025;  dir_vec[2] = 30'd1048576;
        dir_vec[3] = 30'd1023;       dir_vec[4] = 30'd1024;  dir_vec[5] = 30'd1022;
        dir_vec[6] = 30'd2047;       dir_vec[7] = 30'h3FF003FF; dir_vec[8] = 30'd1073741823;
        foreach (dir_vec[i]) send(dir_vec[i]);
        idle(4);
        chk("dir_last_out", last_out_x, 1073741823);

        // Backpressure: two accepted, third stalls, all three drain in order
        out_ready = 1'b0;
        base = n_out;
        send(30'd123456789);
        send(30'd987654321);
        in_valid = 1'b1; in_data = 30'd555555555;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(30'd555555555);
        idle(5);
        chk("bp_drained", n_out - base, 3);
        chk("bp_last_out", last_out_x, 555555555);

        // Randomized traffic
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    idle($urandom_range(0, 2));
                    send(pick_x());
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_count", n_out, n_in);

        // Async reset with two items in flight
        out_ready = 1'b0;
        send(30'd11111);
        send(30'd22222);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        hold_pend = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_x", {x1, x2, x3}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);
        base = n_out;
        out_ready = 1'b1;
        send(30'd33333);
        idle(4);
        chk("post_rst_count", n_out - base, 1);
        chk("post_rst_first", last_out_x, 33333);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
